// File: rtl/master_rd_checker.sv
// Read-response checker for one bus master port: tracks accepted reads in an in-order FIFO
// and flags mismatching, unexpected, overflowing and stalled responses through sticky status.
module master_rd_checker #(
    parameter int            MNUM      = 0,
    parameter int            AW        = 32,
    parameter int            DW        = 32,
    parameter int            DEPTH_LOG = 3,
    parameter int            MODE      = 0,
    parameter logic [DW-1:0] XOR_KEY   = '0,
    parameter int            TIMEOUT   = 1024,
    parameter int            FATAL_EN  = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 master_req,
    input  logic [AW-1:0]        master_addr,
    input  logic                 master_cmd,
    input  logic [DW-1:0]        master_wdata,
    input  logic                 master_ack,
    input  logic [DW-1:0]        master_rdata,
    input  logic                 master_resp,
    input  logic                 clr_i,
    output logic                 rdreq_fifo_full,
    output logic [DEPTH_LOG:0]   outstanding_o,
    output logic                 err_o,
    output logic [3:0]           err_code_o,
    output logic [AW-1:0]        err_addr_o,
    output logic [DW-1:0]        err_exp_o,
    output logic [DW-1:0]        err_got_o,
    output logic [31:0]          resp_cnt_o,
    output logic [15:0]          err_cnt_o
);

    localparam int               DEPTH    = 2 ** DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [31:0]      TO_VAL   = 32'(TIMEOUT);
    localparam logic [31:0]      TO_M1    = TO_VAL - 32'd1;
    localparam bit               WD_EN    = (TIMEOUT != 0);

    logic [AW-1:0]        mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG:0]   count, count_next;
    logic [31:0]          wd;
    logic [AW-1:0]        head;
    logic [DW-1:0]        head_ext, exp_data;
    logic                 push_req, push, pop, empty, full;
    logic                 mismatch, unexp, overflow, timeout, any_err;

    // Write data, master index and the fatal switch only matter to bench-side messaging.
    logic unused_ok;
    assign unused_ok = ^{master_wdata, 32'(MNUM), 32'(FATAL_EN)};

    assign head = mem[rd_ptr];

    generate
        if (AW >= DW) begin : g_trunc
            assign head_ext = head[DW-1:0];
        end else begin : g_ext
            assign head_ext = {{(DW - AW){1'b0}}, head};
        end
    endgenerate

    assign exp_data        = (MODE == 1) ? (head_ext ^ XOR_KEY) : head_ext;
    assign rdreq_fifo_full = full;
    assign outstanding_o   = count;

    always_comb begin
        push_req = master_req & master_ack & ~master_cmd;
        empty    = (count == '0);
        full     = (count == FULL_CNT);
        pop      = master_resp & ~empty;
        unexp    = master_resp & empty;
        overflow = push_req & full & ~pop;
        push     = push_req & ~overflow;
        mismatch = pop & (master_rdata != exp_data);
        timeout  = WD_EN & ~empty & ~pop & (wd == TO_M1);
        any_err  = mismatch | unexp | overflow | timeout;
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + (DEPTH_LOG + 1)'(1);
            2'b01:   count_next = count - (DEPTH_LOG + 1)'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= master_addr;
        end
    end

    // FIFO keeps tracking the bus during clr_i so it stays aligned with real traffic.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            wd         <= '0;
            err_o      <= 1'b0;
            err_code_o <= '0;
            err_addr_o <= '0;
            err_exp_o  <= '0;
            err_got_o  <= '0;
            resp_cnt_o <= '0;
            err_cnt_o  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            if (clr_i) begin
                wd         <= '0;
                err_o      <= 1'b0;
                err_code_o <= '0;
                err_addr_o <= '0;
                err_exp_o  <= '0;
                err_got_o  <= '0;
                resp_cnt_o <= '0;
                err_cnt_o  <= '0;
            end else begin
                // Watchdog stops at TIMEOUT so one stall reports once until the next pop.
                if (empty || pop) begin
                    wd <= '0;
                end else if (WD_EN && (wd < TO_VAL)) begin
                    wd <= wd + 32'd1;
                end
                if (master_resp) begin
                    resp_cnt_o <= resp_cnt_o + 32'd1;
                end
                if (any_err) begin
                    err_o      <= 1'b1;
                    err_code_o <= err_code_o | {timeout, overflow, unexp, mismatch};
                    if (err_cnt_o != 16'hFFFF) begin
                        err_cnt_o <= err_cnt_o + 16'd1;
                    end
                    if (!err_o) begin
                        if (mismatch || timeout) begin
                            err_addr_o <= head;
                        end
                        if (mismatch) begin
                            err_exp_o <= exp_data;
                        end
                        if (mismatch || unexp) begin
                            err_got_o <= master_rdata;
                        end
                    end
                end
            end
        end
    end

endmodule
